tbm_event_decoder: RTL and testbench

- Reader/parser for the 16-bit soft-TBM DAQ word stream (header A0/80, ROC data, trailer E0/C0) at the DAQ side.
- Frames events, extracts trigger counter, trigger position, trailer flags, stack size and ROC word count.
- Flags framing and sequence errors.
- Presents one registered event record per complete event to the DAQ monitor/histogram logic.

---
 rtl/tbm_event_decoder.sv | 128 ++++++++++++
 tb/tb_tbm_event_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tbm_event_decoder.sv
// tbm_event_decoder: frames the 16-bit soft-TBM DAQ stream into one registered event record per
// complete event and flags framing/sequence errors.
// Optional macro TBM_SEQ_CHECK_EN adds a trigger-counter continuity check (err code 5).
module tbm_event_decoder #(
   parameter int NWORDS_W = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sync,
   input  logic                din_valid,
   input  logic [15:0]         din,
   output logic                ev_valid,
   output logic [7:0]          ev_counter,
   output logic [3:0]          ev_pos,
   output logic [7:0]          ev_trl_flags,
   output logic                ev_ares,
   output logic                ev_pkam,
   output logic [3:0]          ev_stack,
   output logic [NWORDS_W-1:0] ev_nwords,
   output logic                err,
   output logic [2:0]          err_code
);
   localparam logic [1:0] IDLE = 2'd0, WH2 = 2'd1, BODY = 2'd2, WT2 = 2'd3;
   localparam logic [NWORDS_W-1:0] NW_MAX = '1;

   logic [1:0]          state, state_n;
   logic                acc, frm, h1, h2, t1, t2, data;
   logic [7:0]          cnt_lat, flg_lat;
   logic [3:0]          pos_lat;
   logic [NWORDS_W-1:0] nwords;
   logic                done, eset, seq_bad;
   logic [2:0]          ecode;

   assign acc  = sync & din_valid;
   assign frm  = din[11:8] == 4'h0;
   assign h1   = frm && din[15:12] == 4'hA;
   assign h2   = frm && din[15:12] == 4'h8;
   assign t1   = frm && din[15:12] == 4'hE;
   assign t2   = frm && din[15:12] == 4'hC;
   assign data = ~(h1 | h2 | t1 | t2);

`ifdef TBM_SEQ_CHECK_EN
   logic ref_ok;
   // the last delivered ev_counter is the continuity reference; a sync trailer flag restarts at 0
   assign seq_bad = ref_ok && (cnt_lat != (flg_lat[3] ? 8'h00 : ev_counter + 8'd1));
   // reference is trusted only after a completed event with no abort since
   always_ff @(posedge clk or posedge reset)
      if (reset) ref_ok <= 1'b0;
      else if (done) ref_ok <= 1'b1;
      else if (eset && ecode inside {3'd2, 3'd3, 3'd4}) ref_ok <= 1'b0;
`else
   assign seq_bad = 1'b0;
`endif

   // next state, error cause and event completion for the accepted word
   always_comb begin
      state_n = state;
      eset    = 1'b0;
      ecode   = 3'd0;
      done    = 1'b0;
      if (acc)
         case (state)
            IDLE:
               if (h1) state_n = WH2;
               else begin eset = 1'b1; ecode = 3'd1; end
            WH2:
               if (h2) state_n = BODY;
               else begin eset = 1'b1; ecode = 3'd2; state_n = h1 ? WH2 : IDLE; end
            BODY:
               if (t1) begin state_n = WT2; eset = nwords == NW_MAX; ecode = 3'd6; end
               else if (!data) begin eset = 1'b1; ecode = 3'd3; state_n = h1 ? WH2 : IDLE; end
            default:
               if (t2) begin state_n = IDLE; done = 1'b1; eset = seq_bad; ecode = 3'd5; end
               else begin eset = 1'b1; ecode = 3'd4; state_n = h1 ? WH2 : IDLE; end
         endcase
   end

   // framing state and per-event field latches, advanced only on accepted words
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= IDLE;
         cnt_lat <= '0;
         pos_lat <= '0;
         flg_lat <= '0;
         nwords  <= '0;
      end else if (acc) begin
         state <= state_n;
         if (h1) cnt_lat <= din[7:0];
         if (state == WH2 && h2) begin
            pos_lat <= din[3:0];
            nwords  <= '0;
         end
         if (state == BODY && data && nwords != NW_MAX) nwords <= nwords + NWORDS_W'(1);
         if (state == BODY && t1) flg_lat <= din[7:0];
      end

   // one-clk pulses and held error cause
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ev_valid <= 1'b0;
         err      <= 1'b0;
         err_code <= '0;
      end else begin
         ev_valid <= done;
         err      <= eset;
         if (eset) err_code <= ecode;
      end

   // event record, loaded only when trailer2 completes an event
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ev_counter   <= '0;
         ev_pos       <= '0;
         ev_trl_flags <= '0;
         ev_ares      <= 1'b0;
         ev_pkam      <= 1'b0;
         ev_stack     <= '0;
         ev_nwords    <= '0;
      end else if (done) begin
         ev_counter   <= cnt_lat;
         ev_pos       <= pos_lat;
         ev_trl_flags <= flg_lat;
         ev_ares      <= din[7];
         ev_pkam      <= din[6];
         ev_stack     <= din[3:0];
         ev_nwords    <= nwords;
      end
endmodule

// File: tb/tb_tbm_event_decoder.sv
// tb_tbm_event_decoder: table-driven directed vectors plus hand-written multi-cycle sequences.
module tb_tbm_event_decoder;
   localparam int NW = 4;
`ifdef TBM_SEQ_CHECK_EN
   localparam logic SEQ = 1'b1;
`else
   localparam logic SEQ = 1'b0;
`endif
   localparam logic [2:0] C5 = SEQ ? 3'd5 : 3'd0;

   typedef struct packed {
      logic [7:0]    cnt;
      logic [3:0]    pos;
      logic [NW-1:0] nw;
      logic [7:0]    fl;
      logic          ar;
      logic          pk;
      logic [3:0]    stk;
   } rec_t;

   typedef struct {
      logic        rs;
      logic [15:0] din;
      logic        ev;
      logic        er;
      logic [2:0]  code;
      rec_t        rec;
   } vec_t;

   logic          clk = 1'b0, reset = 1'b0, sync = 1'b0, din_valid = 1'b0;
   logic [15:0]   din = '0;
   logic          ev_valid, ev_ares, ev_pkam, err;
   logic [7:0]    ev_counter, ev_trl_flags;
   logic [3:0]    ev_pos, ev_stack;
   logic [NW-1:0] ev_nwords;
   logic [2:0]    err_code;

   int   n_vec = 0, n_bad = 0;
   rec_t exp_rec = '0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   tbm_event_decoder #(.NWORDS_W(NW)) dut (
      .clk(clk), .reset(reset), .sync(sync), .din_valid(din_valid), .din(din),
      .ev_valid(ev_valid), .ev_counter(ev_counter), .ev_pos(ev_pos),
      .ev_trl_flags(ev_trl_flags), .ev_ares(ev_ares), .ev_pkam(ev_pkam),
      .ev_stack(ev_stack), .ev_nwords(ev_nwords), .err(err), .err_code(err_code)
   );

   function automatic rec_t R(input logic [7:0] c, input logic [3:0] p, input logic [NW-1:0] n,
                              input logic [7:0] f, input logic a, input logic k, input logic [3:0] s);
      return {c, p, n, f, a, k, s};
   endfunction

   function automatic vec_t V(input logic rs, input logic [15:0] d, input logic ev, input logic er,
                              input logic [2:0] code, input rec_t r = '0);
      vec_t v;
      v.rs = rs; v.din = d; v.ev = ev; v.er = er; v.code = code; v.rec = r;
      return v;
   endfunction

   task automatic chk(input string nm, input logic ev, input logic er, input logic [2:0] code);
      rec_t a;
      a = {ev_counter, ev_pos, ev_nwords, ev_trl_flags, ev_ares, ev_pkam, ev_stack};
      n_vec++;
      if (ev_valid !== ev || err !== er || err_code !== code || a !== exp_rec) begin
         n_bad++;
         $display("FAIL %s: got ev_valid=%0b err=%0b err_code=%0d rec=%h, expected %0b %0b %0d %h",
                  nm, ev_valid, err, err_code, a, ev, er, code, exp_rec);
      end
   endtask

   task automatic do_reset();
      sync = 1'b0; din_valid = 1'b0; din = '0;
      @(negedge clk);
      reset = 1'b1;
      exp_rec = '0;
      #1 chk("reset", 1'b0, 1'b0, 3'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic apply(input vec_t v, input string nm);
      if (v.rs) do_reset();
      sync = 1'b1; din_valid = 1'b1; din = v.din;
      @(negedge clk);
      if (v.ev) exp_rec = v.rec;
      chk(nm, v.ev, v.er, v.code);
   endtask

   task automatic hold(input logic s, input logic dv, input logic [15:0] d, input logic [2:0] code,
                       input string nm);
      sync = s; din_valid = dv; din = d;
      @(negedge clk);
      chk(nm, 1'b0, 1'b0, code);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      // basic event
      tbl.push_back(V(1, 16'hA005, 0, 0, 0));
      tbl.push_back(V(0, 16'h8003, 0, 0, 0));
      tbl.push_back(V(0, 16'h4123, 0, 0, 0));
      tbl.push_back(V(0, 16'h4456, 0, 0, 0));
      tbl.push_back(V(0, 16'hE088, 0, 0, 0));
      tbl.push_back(V(0, 16'hC012, 1, 0, 0, R(8'h05, 4'h3, 2, 8'h88, 0, 0, 4'h2)));
      // word outside event, then clean empty event
      tbl.push_back(V(1, 16'hE000, 0, 1, 1));
      tbl.push_back(V(0, 16'hA001, 0, 0, 1));
      tbl.push_back(V(0, 16'h8000, 0, 0, 1));
      tbl.push_back(V(0, 16'hE000, 0, 0, 1));
      tbl.push_back(V(0, 16'hC000, 1, 0, 1, R(8'h01, 4'h0, 0, 8'h00, 0, 0, 4'h0)));
      // header1 inside body aborts and restarts
      tbl.push_back(V(1, 16'hA010, 0, 0, 0));
      tbl.push_back(V(0, 16'h8000, 0, 0, 0));
      tbl.push_back(V(0, 16'h4001, 0, 0, 0));
      tbl.push_back(V(0, 16'hA011, 0, 1, 3));
      tbl.push_back(V(0, 16'h8002, 0, 0, 3));
      tbl.push_back(V(0, 16'hE000, 0, 0, 3));
      tbl.push_back(V(0, 16'hC000, 1, 0, 3, R(8'h11, 4'h2, 0, 8'h00, 0, 0, 4'h0)));
      // bad word in WT2 returns to IDLE (next data word is outside event)
      tbl.push_back(V(0, 16'hA020, 0, 0, 3));
      tbl.push_back(V(0, 16'h8000, 0, 0, 3));
      tbl.push_back(V(0, 16'hE000, 0, 0, 3));
      tbl.push_back(V(0, 16'h4000, 0, 1, 4));
      tbl.push_back(V(0, 16'h4000, 0, 1, 1));
      // header1 in WH2 relatches and stays; ares/pkam/stack from trailer2
      tbl.push_back(V(0, 16'hA030, 0, 0, 1));
      tbl.push_back(V(0, 16'hA031, 0, 1, 2));
      tbl.push_back(V(0, 16'h8001, 0, 0, 2));
      tbl.push_back(V(0, 16'hE000, 0, 0, 2));
      tbl.push_back(V(0, 16'hC0C5, 1, 0, 2, R(8'h31, 4'h1, 0, 8'h00, 1, 1, 4'h5)));
      // WH2 data -> IDLE; BODY header2 / trailer2 -> IDLE
      tbl.push_back(V(0, 16'hA040, 0, 0, 2));
      tbl.push_back(V(0, 16'h4000, 0, 1, 2));
      tbl.push_back(V(0, 16'h4000, 0, 1, 1));
      tbl.push_back(V(0, 16'hA050, 0, 0, 1));
      tbl.push_back(V(0, 16'h8000, 0, 0, 1));
      tbl.push_back(V(0, 16'h8000, 0, 1, 3));
      tbl.push_back(V(0, 16'h4000, 0, 1, 1));
      tbl.push_back(V(0, 16'hA07F, 0, 0, 1));
      tbl.push_back(V(0, 16'h8000, 0, 0, 1));
      tbl.push_back(V(0, 16'hC000, 0, 1, 3));
      tbl.push_back(V(0, 16'h4000, 0, 1, 1));
      // framing nibbles with nonzero [11:8] count as data
      tbl.push_back(V(0, 16'hA060, 0, 0, 1));
      tbl.push_back(V(0, 16'h8000, 0, 0, 1));
      tbl.push_back(V(0, 16'hA100, 0, 0, 1));
      tbl.push_back(V(0, 16'hE100, 0, 0, 1));
      tbl.push_back(V(0, 16'hE000, 0, 0, 1));
      tbl.push_back(V(0, 16'hC000, 1, 0, 1, R(8'h60, 4'h0, 2, 8'h00, 0, 0, 4'h0)));
      // counter continuity: 07, 08, 0A (gap), 00 with sync flag
      tbl.push_back(V(1, 16'hA007, 0, 0, 0));
      tbl.push_back(V(0, 16'h8000, 0, 0, 0));
      tbl.push_back(V(0, 16'hE000, 0, 0, 0));
      tbl.push_back(V(0, 16'hC000, 1, 0, 0, R(8'h07, 4'h0, 0, 8'h00, 0, 0, 4'h0)));
      tbl.push_back(V(0, 16'hA008, 0, 0, 0));
      tbl.push_back(V(0, 16'h8000, 0, 0, 0));
      tbl.push_back(V(0, 16'hE000, 0, 0, 0));
      tbl.push_back(V(0, 16'hC000, 1, 0, 0, R(8'h08, 4'h0, 0, 8'h00, 0, 0, 4'h0)));
      tbl.push_back(V(0, 16'hA00A, 0, 0, 0));
      tbl.push_back(V(0, 16'h8000, 0, 0, 0));
      tbl.push_back(V(0, 16'hE000, 0, 0, 0));
      tbl.push_back(V(0, 16'hC000, 1, SEQ, C5, R(8'h0A, 4'h0, 0, 8'h00, 0, 0, 4'h0)));
      tbl.push_back(V(0, 16'hA000, 0, 0, C5));
      tbl.push_back(V(0, 16'h8000, 0, 0, C5));
      tbl.push_back(V(0, 16'hE008, 0, 0, C5));
      tbl.push_back(V(0, 16'hC000, 1, 0, C5, R(8'h00, 4'h0, 0, 8'h08, 0, 0, 4'h0)));

      foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

      // word-count saturation: code 6 at trailer1, count pinned at max
      apply(V(1, 16'hA070, 0, 0, 0), "sat_h1");
      apply(V(0, 16'h8000, 0, 0, 0), "sat_h2");
      for (int i = 0; i < 20; i++) apply(V(0, 16'h4000, 0, 0, 0), "sat_data");
      apply(V(0, 16'hE000, 0, 1, 6), "sat_t1");
      apply(V(0, 16'hC000, 1, 0, 6, R(8'h70, 4'h0, 4'hF, 8'h00, 0, 0, 4'h0)), "sat_t2");

      // basic event again with sync low and din_valid low cycles interleaved
      do_reset();
      for (int i = 0; i < 6; i++) begin
         hold(1'b0, 1'b1, tbl[i].din, 3'd0, "sync_low");
         hold(1'b1, 1'b0, tbl[i].din, 3'd0, "valid_low");
         v = tbl[i];
         v.rs = 1'b0;
         apply(v, "sync_alt");
      end

      // reset in the middle of an event discards it silently
      apply(V(0, 16'hA005, 0, 0, 0), "mid_h1");
      apply(V(0, 16'h8000, 0, 0, 0), "mid_h2");
      do_reset();
      apply(V(0, 16'h8000, 0, 1, 1), "post_rst_idle");
      apply(V(0, 16'hA009, 0, 0, 1), "post_h1");
      apply(V(0, 16'h8000, 0, 0, 1), "post_h2");
      apply(V(0, 16'hE000, 0, 0, 1), "post_t1");
      apply(V(0, 16'hC000, 1, 0, 1, R(8'h09, 4'h0, 0, 8'h00, 0, 0, 4'h0)), "post_t2");
      hold(1'b0, 1'b0, 16'h0000, 3'd1, "post_quiet");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
